// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit CPU: instruction word geometry and
// the state encoding of the boot-time instruction memory loader.
package cpu24_pkg;

    localparam int INSTR_W     = 24;
    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DEPTH  = 256;
    localparam int LDR_CNT_W   = 16;

    typedef enum logic [3:0] {
        LDR_IDLE   = 4'd0,
        LDR_HDR_HI = 4'd1,
        LDR_HDR_LO = 4'd2,
        LDR_B2     = 4'd3,
        LDR_B1     = 4'd4,
        LDR_B0     = 4'd5,
        LDR_WRITE  = 4'd6,
        LDR_DONE   = 4'd7,
        LDR_ERROR  = 4'd8
    } ldr_state_t;

    // Only the header and payload states take bytes from the stream.
    function automatic logic ldr_accepts(input ldr_state_t s);
        return (s == LDR_HDR_HI) || (s == LDR_HDR_LO) ||
               (s == LDR_B2) || (s == LDR_B1) || (s == LDR_B0);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles three stream bytes, most significant first, into one
// instruction word; the byte index selects the lane of the next byte.
module byte_packer
    import cpu24_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_push,
    input  logic [7:0]         i_byte,
    output logic [INSTR_W-1:0] o_word
);

    logic [INSTR_W-1:0] r_word;
    logic [1:0]         r_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_index <= 2'd0;
        end else if (i_clear) begin
            r_index <= 2'd0;
        end else if (i_push) begin
            case (r_index)
                2'd0:    r_word[23:16] <= i_byte;
                2'd1:    r_word[15:8]  <= i_byte;
                default: r_word[7:0]   <= i_byte;
            endcase
            r_index <= (r_index == 2'd2) ? 2'd0 : r_index + 2'd1;
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: reads a word-count header and packed 24-bit words from
// a byte stream, writes them to instruction memory, and holds the CPU until done.
module imem_loader
    import cpu24_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [7:0]        i_in_byte,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_error
);

    ldr_state_t           r_state;
    ldr_state_t           w_next;
    logic [LDR_CNT_W-1:0] r_count;
    logic [LDR_CNT_W-1:0] r_n;
    logic [LDR_CNT_W-1:0] w_n_full;
    logic                 w_in_ready;
    logic                 w_xfer;
    logic                 w_start_load;
    logic                 w_hdr_hi_we;
    logic                 w_hdr_lo_we;
    logic                 w_pack;
    logic                 w_word_done;
    logic [INSTR_W-1:0]   w_word;

    assign w_in_ready = ldr_accepts(r_state);
    assign w_xfer     = i_in_valid && w_in_ready;
    assign w_n_full   = {r_n[15:8], i_in_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LDR_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_start_load = 1'b0;
        w_hdr_hi_we  = 1'b0;
        w_hdr_lo_we  = 1'b0;
        w_pack       = 1'b0;
        w_word_done  = 1'b0;
        case (r_state)
            LDR_IDLE, LDR_DONE, LDR_ERROR: begin
                if (i_start) begin
                    w_next       = LDR_HDR_HI;
                    w_start_load = 1'b1;
                end
            end
            LDR_HDR_HI: begin
                if (w_xfer) begin
                    w_hdr_hi_we = 1'b1;
                    w_next      = LDR_HDR_LO;
                end
            end
            LDR_HDR_LO: begin
                if (w_xfer) begin
                    w_hdr_lo_we = 1'b1;
                    if (w_n_full == '0)                w_next = LDR_DONE;
                    else if (int'(w_n_full) > DEPTH)   w_next = LDR_ERROR;
                    else                               w_next = LDR_B2;
                end
            end
            LDR_B2: begin
                if (w_xfer) begin
                    w_pack = 1'b1;
                    w_next = LDR_B1;
                end
            end
            LDR_B1: begin
                if (w_xfer) begin
                    w_pack = 1'b1;
                    w_next = LDR_B0;
                end
            end
            LDR_B0: begin
                if (w_xfer) begin
                    w_pack = 1'b1;
                    w_next = LDR_WRITE;
                end
            end
            LDR_WRITE: begin
                w_word_done = 1'b1;
                w_next = ((r_count + 16'd1) == r_n) ? LDR_DONE : LDR_B2;
            end
            default: w_next = LDR_IDLE;
        endcase
    end

    // Word counter doubles as the write address; header is kept for the end test.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_n     <= '0;
        end else begin
            if (w_start_load) begin
                r_count <= '0;
                r_n     <= '0;
            end else if (w_word_done) begin
                r_count <= r_count + 16'd1;
            end
            if (w_hdr_hi_we) r_n[15:8] <= i_in_byte;
            if (w_hdr_lo_we) r_n[7:0]  <= i_in_byte;
        end
    end

    byte_packer u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start_load),
        .i_push  (w_pack),
        .i_byte  (i_in_byte),
        .o_word  (w_word)
    );

    assign o_in_ready = w_in_ready;
    assign o_mem_we   = (r_state == LDR_WRITE);
    assign o_mem_addr = r_count[ADDR_W-1:0];
    assign o_mem_data = w_word;
    assign o_done     = (r_state == LDR_DONE);
    assign o_error    = (r_state == LDR_ERROR);
    assign o_cpu_hold = (r_state != LDR_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as bytes
// are streamed and popped by a write monitor when the DUT pulses MemWe.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  inByte;
    logic        inValid;
    logic        inReady;
    logic        memWe;
    logic [7:0]  memAddr;
    logic [23:0] memData;
    logic        cpuHold;
    logic        done;
    logic        error;

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          writesSeen  = 0;
    int          pushCount   = 0;
    logic [31:0] sbQueue[$];

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (start),
        .i_in_byte  (inByte),
        .i_in_valid (inValid),
        .o_in_ready (inReady),
        .o_mem_we   (memWe),
        .o_mem_addr (memAddr),
        .o_mem_data (memData),
        .o_cpu_hold (cpuHold),
        .o_done     (done),
        .o_error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge; holds the byte until it is accepted.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waited;
        inValid = 1'b0;
        repeat (gap) @(negedge clk);
        inValid = 1'b1;
        inByte  = b;
        waited  = 0;
        while (!inReady && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            testsRun++;
            testsFailed++;
            $error("FAIL byte_accept_timeout: observed no InReady expected InReady within 50 cycles");
        end
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expectWrite(input logic [7:0] addr, input logic [23:0] data);
        sbQueue.push_back({addr, data});
        pushCount++;
    endtask

    always @(negedge clk) begin
        logic [31:0] exp;
        if (rst_n === 1'b1 && memWe === 1'b1) begin
            writesSeen++;
            testsRun++;
            assert (sbQueue.size() != 0) else begin
                testsFailed++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", memAddr, memData);
            end
            if (sbQueue.size() != 0) begin
                exp = sbQueue.pop_front();
                checkOutput("wr_addr", 32'(memAddr), 32'(exp[31:24]));
                checkOutput("wr_data", 32'(memData), 32'(exp[23:0]));
            end
        end
    end

    initial begin
        logic [7:0] b2, b1, b0;
        rst_n   = 1'b0;
        start   = 1'b0;
        inValid = 1'b0;
        inByte  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: {hold,done,error,ready,we}
        for (int i = 0; i < 20; i++) begin
            checkOutput("idle_outputs", 32'({cpuHold, done, error, inReady, memWe}), 32'(5'b10000));
            @(negedge clk);
        end

        // Two-word image
        pulseStart();
        checkOutput("hdr_ready", 32'({cpuHold, inReady}), 32'(2'b11));
        applyStimulus(8'h00, 0);
        applyStimulus(8'h02, 0);
        expectWrite(8'h00, 24'h123456);
        applyStimulus(8'h12, 0);
        applyStimulus(8'h34, 0);
        applyStimulus(8'h56, 0);
        expectWrite(8'h01, 24'hABCDEF);
        applyStimulus(8'hAB, 0);
        applyStimulus(8'hCD, 0);
        applyStimulus(8'hEF, 0);
        checkOutput("last_write_we", 32'(memWe), 32'(1));
        @(negedge clk);
        checkOutput("two_word_done", 32'({cpuHold, done, error, inReady, memWe}), 32'(5'b01000));
        checkOutput("two_word_queue", 32'(sbQueue.size()), 32'(0));

        // Empty image straight from DONE
        pulseStart();
        checkOutput("reload_hold", 32'({cpuHold, done}), 32'(2'b10));
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        checkOutput("empty_done", 32'({cpuHold, done, error, memWe}), 32'(4'b0100));

        // Oversized header
        pulseStart();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h01, 0);
        checkOutput("oversize_error", 32'({cpuHold, done, error, inReady, memWe}), 32'(5'b10100));
        inValid = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("error_sticky", 32'({cpuHold, error, inReady}), 32'(3'b110));
        inValid = 1'b0;
        pulseStart();
        checkOutput("error_recover", 32'({error, inReady}), 32'(2'b01));
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        expectWrite(8'h00, 24'h112233);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'h33, 0);
        @(negedge clk);
        checkOutput("recover_done", 32'({cpuHold, done}), 32'(2'b01));

        // Full-depth image with random gaps
        pulseStart();
        applyStimulus(8'h01, $urandom_range(0, 2));
        applyStimulus(8'h00, $urandom_range(0, 2));
        for (int w = 0; w < 256; w++) begin
            b2 = 8'($urandom);
            b1 = 8'($urandom);
            b0 = 8'($urandom);
            expectWrite(8'(w), {b2, b1, b0});
            applyStimulus(b2, $urandom_range(0, 2));
            applyStimulus(b1, $urandom_range(0, 2));
            applyStimulus(b0, $urandom_range(0, 2));
            if (w == 255) checkOutput("last_addr", 32'(memAddr), 32'(8'hFF));
        end
        @(negedge clk);
        checkOutput("full_done", 32'({cpuHold, done, error}), 32'(3'b010));
        checkOutput("full_queue", 32'(sbQueue.size()), 32'(0));

        // Reset in the middle of word 1
        pulseStart();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h12, 0);
        applyStimulus(8'h34, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_ctrl", 32'({cpuHold, done, error, inReady, memWe}), 32'(5'b10000));
        checkOutput("midreset_addr", 32'(memAddr), 32'(0));
        checkOutput("midreset_data", 32'(memData), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulseStart();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        expectWrite(8'h00, 24'h9ABCDE);
        applyStimulus(8'h9A, 0);
        pulseStart();
        checkOutput("start_ignored", 32'({inReady, done}), 32'(2'b10));
        applyStimulus(8'hBC, 0);
        applyStimulus(8'hDE, 0);
        @(negedge clk);
        checkOutput("reload_done", 32'({cpuHold, done}), 32'(2'b01));

        repeat (3) @(negedge clk);
        checkOutput("write_total", 32'(writesSeen), 32'(pushCount));
        checkOutput("final_queue", 32'(sbQueue.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
